// File: rtl/program_loader.sv
// Instruction-memory write side fed by the debug UART.
// Packs bytes MSB-first into words, writes them from address 0 and holds the CPU while loading.
module program_loader #(
  parameter int SIZE_ADDR_PC = 32,
  parameter int SIZE_INST = 32,
  parameter int MEM_DEPTH = 256,
  parameter logic [SIZE_INST-1:0] HALT_WORD = 32'hFFFFFFFF,
  localparam int CW = $clog2(MEM_DEPTH) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_mem_wr_en,
  output logic [SIZE_ADDR_PC-1:0] o_mem_wr_addr,
  output logic [SIZE_INST-1:0]    o_mem_wr_data,
  output logic                    o_cpu_hold,
  output logic                    o_done,
  output logic                    o_error,
  output logic [CW-1:0]           o_word_count
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE,
    ERROR
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(MEM_DEPTH - 1);

  state_t              state;
  logic [23:0]         shift;
  logic [1:0]          nbyte;
  logic [CW-1:0]       index;
  logic [SIZE_INST-1:0] word_w;

  assign word_w = SIZE_INST'({shift, i_rx_data});

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      shift         <= '0;
      nbyte         <= '0;
      index         <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
      o_cpu_hold    <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= '0;
    end else begin
      o_mem_wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            state        <= RECV;
            shift        <= '0;
            nbyte        <= '0;
            index        <= '0;
            o_word_count <= '0;
            o_cpu_hold   <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            shift <= word_w[23:0];
            nbyte <= nbyte + 2'd1;
            // 4th byte: the write itself appears next cycle
            if (nbyte == 2'd3) begin
              o_mem_wr_en   <= 1'b1;
              o_mem_wr_addr <= SIZE_ADDR_PC'({index, 2'b00});
              o_mem_wr_data <= word_w;
              o_word_count  <= o_word_count + CW'(1);
              if (word_w == HALT_WORD) begin
                state      <= DONE;
                o_done     <= 1'b1;
                o_cpu_hold <= 1'b0;
              end else if (index == LAST) begin
                state      <= ERROR;
                o_error    <= 1'b1;
                o_cpu_hold <= 1'b0;
              end else begin
                index <= index + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a word-level reference model.
// Directed sequences pin the model with literal expectations.
module tb_program_loader;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          hold;
  logic          done;
  logic          err;
  logic [CW-1:0] wcount;

  program_loader #(
    .SIZE_ADDR_PC(32),
    .SIZE_INST(32),
    .MEM_DEPTH(DEPTH),
    .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_start(start),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_mem_wr_en(wr_en),
    .o_mem_wr_addr(wr_addr),
    .o_mem_wr_data(wr_data),
    .o_cpu_hold(hold),
    .o_done(done),
    .o_error(err),
    .o_word_count(wcount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_load;
  bit          m_done;
  bit          m_err;
  bit          m_wen;
  int          m_nb;
  int          m_wc;
  logic [31:0] m_acc;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  bit          bias;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_done = 0; m_err = 0; m_wen = 0;
    m_nb = 0; m_wc = 0; m_acc = '0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_step(input bit s, input bit v,
                            input logic [7:0] d);
    m_wen = 0;
    if (!m_load) begin
      if (s) begin
        m_load = 1; m_done = 0; m_err = 0;
        m_nb = 0; m_wc = 0; m_acc = '0;
      end
    end else if (v) begin
      m_acc = (m_acc << 8) | 32'(d);
      m_nb++;
      if (m_nb == 4) begin
        m_nb = 0;
        m_wen = 1;
        m_addr = 32'(m_wc * 4);
        m_data = m_acc;
        m_wc++;
        if (m_acc == 32'hFFFFFFFF) begin
          m_load = 0; m_done = 1;
        end else if (m_wc == DEPTH) begin
          m_load = 0; m_err = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("wr_en", 32'(wr_en), 32'(m_wen));
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("cpu_hold", 32'(hold), 32'(m_load));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(err), 32'(m_err));
    chk("word_count", 32'(wcount), 32'(m_wc));
  endtask

  // drive one cycle, update the model at the edge, compare at negedge
  task automatic step(input bit s, input bit v, input logic [7:0] d);
    start = s; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_step(s, v, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(0, 1, w[i*8 +: 8]);
  endtask

  task automatic zero_check(input string n);
    chk({n, "_wen"}, 32'(wr_en), 32'd0);
    chk({n, "_addr"}, wr_addr, 32'd0);
    chk({n, "_data"}, wr_data, 32'd0);
    chk({n, "_hold"}, 32'(hold), 32'd0);
    chk({n, "_flags"}, 32'({done, err}), 32'd0);
    chk({n, "_count"}, 32'(wcount), 32'd0);
  endtask

  // async reset pulse, released before the next rising edge
  task automatic do_reset(input string n);
    start = 0; rx_valid = 0; rx_data = '0;
    rst_n = 1'b0;
    #1;
    zero_check(n);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  logic [7:0] b;

  initial begin
    rst_n = 1'b0; start = 0; rx_valid = 0; rx_data = '0;
    model_reset();
    #1;
    zero_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // bytes before start are ignored
    repeat (3) step(0, 1, 8'($urandom));
    step(0, 1, 8'hFF);

    step(1, 0, 8'h00);
    chk("t1_hold", 32'(hold), 32'd1);
    send(32'h20010005);
    chk("t1_wen", 32'(wr_en), 32'd1);
    chk("t1_addr", wr_addr, 32'h0);
    chk("t1_data", wr_data, 32'h20010005);
    chk("t1_count", 32'(wcount), 32'd1);

    send(32'hFFFFFFFF);
    chk("t2_addr", wr_addr, 32'h4);
    chk("t2_data", wr_data, 32'hFFFFFFFF);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hold", 32'(hold), 32'd0);
    chk("t2_count", 32'(wcount), 32'd2);
    step(0, 1, 8'h12);
    chk("t2_hold_wen", 32'(wr_en), 32'd0);
    chk("t2_hold_addr", wr_addr, 32'h4);

    // restart from DONE, then back-to-back bytes
    step(1, 0, 8'h00);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_count", 32'(wcount), 32'd0);
    send(32'h11223344);
    chk("t4_addr0", wr_addr, 32'h0);
    chk("t4_data0", wr_data, 32'h11223344);
    step(0, 1, 8'h55);
    chk("t4_gap_wen", 32'(wr_en), 32'd0);
    step(0, 1, 8'h66);
    step(0, 1, 8'h77);
    step(0, 1, 8'h88);
    chk("t4_addr1", wr_addr, 32'h4);
    chk("t4_data1", wr_data, 32'h55667788);

    // fill the memory without HALT
    step(1, 1, 8'hA0);
    step(0, 1, 8'hA1);
    step(0, 1, 8'hA2);
    step(0, 1, 8'hA3);
    send(32'hB0B1B2B3);
    chk("t5_addr", wr_addr, 32'hC);
    chk("t5_error", 32'(err), 32'd1);
    chk("t5_count", 32'(wcount), 32'd4);
    repeat (8) step(0, 1, 8'hFF);
    chk("t5_after_count", 32'(wcount), 32'd4);
    chk("t5_after_addr", wr_addr, 32'hC);

    // reset mid-word
    step(1, 0, 8'h00);
    step(0, 1, 8'h99);
    step(0, 1, 8'h98);
    do_reset("t6");
    step(1, 0, 8'h00);
    send(32'hAABBCCDD);
    chk("t6_addr", wr_addr, 32'h0);
    chk("t6_data", wr_data, 32'hAABBCCDD);
    chk("t6_count", 32'(wcount), 32'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit s;
      bit v;
      if ($urandom_range(0, 599) == 0) do_reset("rnd_reset");
      s = m_load ? ($urandom_range(0, 49) == 0)
                 : ($urandom_range(0, 14) == 0);
      if (s && !m_load) bias = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      if (bias) b = ($urandom_range(0, 7) != 0) ? 8'hFF : 8'($urandom);
      else b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(s, v, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
